// File: rtl/dma_wr_packer_pkg.sv
// Shared constants and state type for the DMA write packer slice.
package dma_pkg;

    localparam int unsigned NUM_LANE = 8;
    localparam int unsigned LANE_W   = 3;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned ROW_W    = 32 - LANE_W;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        ISSUE,
        DONE
    } dma_wr_st_t;

endpackage

// File: rtl/dma_wr_packer_if.sv
// Command, word-stream and 8-lane DMA write signals of the packer.
interface dma_wr_packer_if
    import dma_pkg::*;
#(
    parameter int unsigned LEN_W = 16
);

    logic                         i_cmd_valid;
    logic [31:0]                  i_cmd_addr;
    logic                         o_cmd_ready;
    logic                         i_s_valid;
    logic [WORD_W-1:0]            i_s_data;
    logic                         i_s_last;
    logic                         o_s_ready;
    logic                         o_dma_rden;
    logic                         o_dma_wren;
    logic [31:0]                  o_dma_addr;
    logic [NUM_LANE*WORD_W-1:0]   o_dma_wdata;
    logic [NUM_LANE-1:0]          o_dma_wstrb;
    logic [NUM_LANE-1:0]          o_dma_winc;
    logic                         i_dma_gnt;
    logic                         o_done;
    logic [LEN_W-1:0]             o_done_words;
    logic                         o_busy;

    // Packer side.
    modport master (
        input  i_cmd_valid, i_cmd_addr, i_s_valid, i_s_data, i_s_last, i_dma_gnt,
        output o_cmd_ready, o_s_ready, o_dma_rden, o_dma_wren, o_dma_addr,
               o_dma_wdata, o_dma_wstrb, o_dma_winc, o_done, o_done_words, o_busy
    );

    // Environment side: command/stream source and memory port.
    modport slave (
        output i_cmd_valid, i_cmd_addr, i_s_valid, i_s_data, i_s_last, i_dma_gnt,
        input  o_cmd_ready, o_s_ready, o_dma_rden, o_dma_wren, o_dma_addr,
               o_dma_wdata, o_dma_wstrb, o_dma_winc, o_done, o_done_words, o_busy
    );

endinterface

// File: rtl/dma_wr_packer_lane_mask.sv
// Lane strobes for a beat of cnt words starting at lane p; lanes below p wrap into row+1.
module dma_lane_mask
    import dma_pkg::*;
(
    input  logic [LANE_W-1:0]   p,
    input  logic [LANE_W:0]     cnt,
    output logic [NUM_LANE-1:0] wstrb,
    output logic [NUM_LANE-1:0] winc
);

    logic [LANE_W-1:0] off;

    always_comb begin
        wstrb = '0;
        winc  = '0;
        off   = '0;
        for (int unsigned i = 0; i < NUM_LANE; i++) begin
            off      = LANE_W'(i) - p;
            wstrb[i] = ({1'b0, off} < cnt);
            winc[i]  = wstrb[i] && (LANE_W'(i) < p);
        end
    end

endmodule

// File: rtl/dma_wr_packer.sv
// Packs a 32-bit word stream into 256-bit beats and writes them to the 8-lane DMA port.
module dma_wr_packer
    import dma_pkg::*;
#(
    parameter int unsigned LEN_W = 16
)
(
    input logic             i_clk,
    input logic             i_rst_n,
    dma_wr_packer_if.master bus
);

    localparam logic [LANE_W:0] CNT_LAST = (LANE_W + 1)'(NUM_LANE - 1);

    dma_wr_st_t          state_q, state_d;
    logic [WORD_W-1:0]   lane_q [NUM_LANE];
    logic [LANE_W-1:0]   p_q;
    logic [ROW_W-1:0]    row_q;
    logic [LANE_W:0]     cnt_q;
    logic [LEN_W-1:0]    total_q;
    logic [LEN_W-1:0]    done_words_q;
    logic                last_q;

    logic                cmd_hs, s_hs, gnt_hs;
    logic [LANE_W:0]     end_pos;
    logic [LANE_W-1:0]   wr_lane;
    logic [NUM_LANE-1:0] mask_wstrb, mask_winc;

    assign cmd_hs  = (state_q == IDLE)  && bus.i_cmd_valid;
    assign s_hs    = (state_q == FILL)  && bus.i_s_valid;
    assign gnt_hs  = (state_q == ISSUE) && bus.i_dma_gnt;
    // Next free lane; its carry bit is the row advance once the beat is granted.
    assign end_pos = {1'b0, p_q} + cnt_q;
    assign wr_lane = end_pos[LANE_W-1:0];

    dma_lane_mask u_mask (
        .p     (p_q),
        .cnt   (cnt_q),
        .wstrb (mask_wstrb),
        .winc  (mask_winc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        bus.o_cmd_ready  = 1'b0;
        bus.o_s_ready    = 1'b0;
        bus.o_dma_wren   = 1'b0;
        bus.o_dma_addr   = '0;
        bus.o_dma_wdata  = '0;
        bus.o_dma_wstrb  = '0;
        bus.o_dma_winc   = '0;
        bus.o_done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.o_cmd_ready = 1'b1;
                if (bus.i_cmd_valid) state_d = FILL;
            end
            FILL: begin
                bus.o_s_ready = 1'b1;
                if (bus.i_s_valid && (bus.i_s_last || cnt_q == CNT_LAST)) state_d = ISSUE;
            end
            ISSUE: begin
                bus.o_dma_wren  = 1'b1;
                bus.o_dma_addr  = {3'b000, row_q};
                bus.o_dma_wstrb = mask_wstrb;
                bus.o_dma_winc  = mask_winc;
                for (int unsigned i = 0; i < NUM_LANE; i++) begin
                    if (mask_wstrb[i]) bus.o_dma_wdata[WORD_W*i +: WORD_W] = lane_q[i];
                end
                if (bus.i_dma_gnt) state_d = last_q ? DONE : FILL;
            end
            DONE: begin
                bus.o_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NUM_LANE; i++) lane_q[i] <= '0;
            p_q          <= '0;
            row_q        <= '0;
            cnt_q        <= '0;
            total_q      <= '0;
            last_q       <= 1'b0;
            done_words_q <= '0;
        end else begin
            if (cmd_hs) begin
                p_q     <= bus.i_cmd_addr[LANE_W-1:0];
                row_q   <= bus.i_cmd_addr[31:LANE_W];
                cnt_q   <= '0;
                total_q <= '0;
                last_q  <= 1'b0;
            end
            if (s_hs) begin
                lane_q[wr_lane] <= bus.i_s_data;
                cnt_q           <= cnt_q + 1'b1;
                total_q         <= total_q + 1'b1;
                if (bus.i_s_last) last_q <= 1'b1;
            end
            if (gnt_hs) begin
                row_q <= row_q + ROW_W'(end_pos[LANE_W]);
                p_q   <= wr_lane;
                cnt_q <= '0;
                if (last_q) done_words_q <= total_q;
            end
        end
    end

    assign bus.o_dma_rden   = 1'b0;
    assign bus.o_done_words = done_words_q;
    assign bus.o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dma_wr_packer.sv
// Randomized scoreboard bench for dma_wr_packer: expected beats derived from word addresses.
module tb_dma_wr_packer;

    localparam int unsigned LEN_W = 16;

    typedef struct packed {
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [7:0]   wstrb;
        logic [7:0]   winc;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dma_wr_packer_if #(.LEN_W(LEN_W)) bus ();

    dma_wr_packer #(.LEN_W(LEN_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    beat_t            exp_q[$];
    logic [LEN_W-1:0] done_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int gnt_pct = 100;
    int sv_pct = 100;
    int hold_left = 0;

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    // Memory-side grant: optionally held low for hold_left ISSUE cycles, otherwise random.
    initial begin
        bus.i_dma_gnt = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.o_dma_wren && hold_left > 0) begin
                bus.i_dma_gnt = 1'b0;
                hold_left--;
            end else begin
                bus.i_dma_gnt = ($urandom_range(0, 99) < gnt_pct);
            end
        end
    end

    // Monitor: compares every accepted beat and every completion against the scoreboard.
    initial begin
        beat_t cur, prev, e;
        logic  prev_stall, prev_done;
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
                continue;
            end
            cur.addr  = bus.o_dma_addr;
            cur.wdata = bus.o_dma_wdata;
            cur.wstrb = bus.o_dma_wstrb;
            cur.winc  = bus.o_dma_winc;
            if (bus.o_dma_wren) begin
                check("s_ready_in_issue", 320'(bus.o_s_ready), 320'(0));
                check("rden", 320'(bus.o_dma_rden), 320'(0));
                if (prev_stall) check("stall_stable", 320'(cur), 320'(prev));
                if (bus.i_dma_gnt) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_beat: got addr %0h expected no beat", cur.addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_addr", 320'(cur.addr), 320'(e.addr));
                        check("beat_wstrb", 320'(cur.wstrb), 320'(e.wstrb));
                        check("beat_winc", 320'(cur.winc), 320'(e.winc));
                        check("beat_wdata", 320'(cur.wdata), 320'(e.wdata));
                    end
                end
            end
            prev_stall = bus.o_dma_wren && !bus.i_dma_gnt;
            prev       = cur;
            if (bus.o_done) begin
                check("done_single_cycle", 320'(prev_done), 320'(0));
                check("done_after_beats", 320'(exp_q.size()), 320'(0));
                if (done_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got words %0d expected no done", bus.o_done_words);
                end else begin
                    check("done_words", 320'(bus.o_done_words), 320'(done_q.pop_front()));
                end
            end
            prev_done = bus.o_done;
        end
    end

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 600 && !ok; t++) begin
            @(negedge clk);
            ok = bus.o_done;
        end
        if (!ok) fail_now("done_timeout");
        @(posedge clk);
        #1;
    endtask

    // Reference: word k lives at address addr+k; beat j holds words 8j..8j+7.
    task automatic run_xfer(input logic [31:0] addr, input int n, input bit wait_end);
        logic [31:0] d[$];
        logic [31:0] fa, wa;
        beat_t       b;
        bit          ok;
        for (int k = 0; k < n; k++) d.push_back($urandom);
        for (int j = 0; j < (n + 7) / 8; j++) begin
            fa     = addr + 32'(8 * j);
            b      = '0;
            b.addr = {3'b000, fa[31:3]};
            for (int k = 8 * j; k < n && k < 8 * j + 8; k++) begin
                wa = addr + 32'(k);
                b.wstrb[wa[2:0]] = 1'b1;
                if (wa[31:3] != fa[31:3]) b.winc[wa[2:0]] = 1'b1;
                b.wdata[32 * wa[2:0] +: 32] = d[k];
            end
            exp_q.push_back(b);
        end
        done_q.push_back(LEN_W'(n));

        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_addr  = addr;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = bus.o_cmd_ready;
            @(posedge clk);
            #1;
        end
        bus.i_cmd_valid = 1'b0;
        if (!ok) begin
            fail_now("cmd_timeout");
            return;
        end

        for (int k = 0; k < n; k++) begin
            while ($urandom_range(0, 99) >= sv_pct) begin
                @(posedge clk);
                #1;
            end
            bus.i_s_valid = 1'b1;
            bus.i_s_data  = d[k];
            bus.i_s_last  = (k == n - 1);
            ok = 1'b0;
            for (int t = 0; t < 200 && !ok; t++) begin
                @(negedge clk);
                ok = bus.o_s_ready;
                @(posedge clk);
                #1;
            end
            bus.i_s_valid = 1'b0;
            bus.i_s_last  = 1'b0;
            if (!ok) begin
                fail_now("word_timeout");
                return;
            end
        end
        if (wait_end) wait_done();
    endtask

    initial begin
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_addr  = '0;
        bus.i_s_valid   = 1'b0;
        bus.i_s_data    = '0;
        bus.i_s_last    = 1'b0;

        #2;
        check("rst_cmd_ready", 320'(bus.o_cmd_ready), 320'(1));
        check("rst_s_ready", 320'(bus.o_s_ready), 320'(0));
        check("rst_wren", 320'(bus.o_dma_wren), 320'(0));
        check("rst_done", 320'(bus.o_done), 320'(0));
        check("rst_busy", 320'(bus.o_busy), 320'(0));
        check("rst_done_words", 320'(bus.o_done_words), 320'(0));
        check("rst_wstrb", 320'(bus.o_dma_wstrb), 320'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_xfer(32'h40, 8, 1'b1);
        run_xfer(32'h45, 3, 1'b1);
        run_xfer(32'h45, 8, 1'b1);
        run_xfer(32'h43, 20, 1'b1);
        hold_left = 5;
        run_xfer(32'h40, 8, 1'b1);
        run_xfer(32'hFFFF_FFFC, 10, 1'b1);

        for (int i = 0; i < 25; i++) begin
            gnt_pct = int'($urandom_range(30, 100));
            sv_pct  = int'($urandom_range(40, 100));
            run_xfer($urandom, int'($urandom_range(1, 24)), 1'b1);
        end
        gnt_pct = 100;
        sv_pct  = 100;

        // Reset while a beat is waiting for grant.
        hold_left = 1000;
        run_xfer(32'h40, 8, 1'b0);
        @(negedge clk);
        check("issue_before_reset", 320'(bus.o_dma_wren), 320'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_wren", 320'(bus.o_dma_wren), 320'(0));
        check("reset_done", 320'(bus.o_done), 320'(0));
        check("reset_cmd_ready", 320'(bus.o_cmd_ready), 320'(1));
        check("reset_busy", 320'(bus.o_busy), 320'(0));
        exp_q.delete();
        done_q.delete();
        hold_left = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_xfer(32'h40, 8, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        check("beats_drained", 320'(exp_q.size()), 320'(0));
        check("dones_drained", 320'(done_q.size()), 320'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
